// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache (one word per line)
// in front of a fixed-latency word memory, with an end-of-program flush.
module dcache_responder #(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        end_signal_i,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        hit,
  output logic        busy,
  output logic        flush_done
);

  localparam int unsigned LINES     = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W     = 32 - INDEX_BITS - 2;
  localparam int unsigned MEM_WORDS = 2 ** MEM_AW;
  localparam int unsigned LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, WB, REFILL, RESP, FLUSH_SCAN, FLUSH_WB, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [INDEX_BITS-1:0]   scan_q, scan_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [LINES-1:0]        dirty_q, dirty_d;
  logic                    end_pend_q, end_pend_d;
  logic [29:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    ack_q, ack_d, hit_q, hit_d, busy_q, busy_d;
  logic                    flush_done_q, flush_done_d;

  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic [31:0]             mem_q  [MEM_WORDS];

  logic                    line_we, mem_we;
  logic [INDEX_BITS-1:0]   line_idx;
  logic [TAG_W-1:0]        line_tag;
  logic [31:0]             line_data, mem_wdata;
  logic [MEM_AW-1:0]       mem_waddr, mem_raddr;

  logic [INDEX_BITS-1:0]   idx_in, req_idx;
  logic [TAG_W-1:0]        tag_in, req_tag;
  logic                    in_hit, lat_last;
  logic [LAT_W-1:0]        lat_next;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];
  assign idx_in    = address[INDEX_BITS+1:2];
  assign tag_in    = address[31:INDEX_BITS+2];
  assign req_idx   = addr_q[INDEX_BITS-1:0];
  assign req_tag   = addr_q[29:INDEX_BITS];
  assign in_hit    = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign lat_last  = (lat_q == LAT_W'(MEM_LATENCY - 1));
  assign lat_next  = lat_last ? '0 : lat_q + LAT_W'(1);
  assign mem_raddr = MEM_AW'(addr_q);

  // Next-state, datapath enables and registered-output values
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    scan_d       = scan_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    end_pend_d   = end_pend_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    data_out_d   = data_out_q;
    ack_d        = 1'b0;
    hit_d        = 1'b0;
    line_we      = 1'b0;
    line_idx     = req_idx;
    line_tag     = req_tag;
    line_data    = wdata_q;
    mem_we       = 1'b0;
    mem_waddr    = MEM_AW'({tag_q[req_idx], req_idx});
    mem_wdata    = data_q[req_idx];

    case (state_q)
      IDLE: begin
        if (end_signal_i || end_pend_q) begin
          state_d    = FLUSH_SCAN;
          end_pend_d = 1'b0;
        end else if (read || write) begin
          addr_d  = address[31:2];
          wdata_d = data_in;
          we_d    = write;
          if (in_hit) begin
            state_d = RESP;
            ack_d   = 1'b1;
            hit_d   = 1'b1;
            if (write) begin
              line_we         = 1'b1;
              line_idx        = idx_in;
              line_tag        = tag_in;
              line_data       = data_in;
              dirty_d[idx_in] = 1'b1;
            end else begin
              data_out_d = data_q[idx_in];
            end
          end else if (dirty_q[idx_in]) begin
            state_d = WB;
          end else if (write) begin
            // Whole line is the stored word, so a write miss needs no refill
            state_d         = RESP;
            ack_d           = 1'b1;
            line_we         = 1'b1;
            line_idx        = idx_in;
            line_tag        = tag_in;
            line_data       = data_in;
            valid_d[idx_in] = 1'b1;
            dirty_d[idx_in] = 1'b1;
          end else begin
            state_d = REFILL;
          end
        end
      end
      WB: begin
        lat_d = lat_next;
        if (lat_last) begin
          mem_we = 1'b1;
          if (we_q) begin
            state_d          = RESP;
            ack_d            = 1'b1;
            line_we          = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end else begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        lat_d = lat_next;
        if (lat_last) begin
          state_d          = RESP;
          ack_d            = 1'b1;
          line_we          = 1'b1;
          line_data        = mem_q[mem_raddr];
          data_out_d       = mem_q[mem_raddr];
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
        end
      end
      RESP: state_d = IDLE;
      FLUSH_SCAN: begin
        if (dirty_q[scan_q]) begin
          state_d = FLUSH_WB;
        end else if (scan_q == INDEX_BITS'(LINES - 1)) begin
          state_d = DONE;
        end else begin
          scan_d = scan_q + INDEX_BITS'(1);
        end
      end
      FLUSH_WB: begin
        lat_d     = lat_next;
        mem_waddr = MEM_AW'({tag_q[scan_q], scan_q});
        mem_wdata = data_q[scan_q];
        if (lat_last) begin
          mem_we          = 1'b1;
          dirty_d[scan_q] = 1'b0;
          if (scan_q == INDEX_BITS'(LINES - 1)) begin
            state_d = DONE;
          end else begin
            state_d = FLUSH_SCAN;
            scan_d  = scan_q + INDEX_BITS'(1);
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // An end request seen mid-transaction waits for the ack, then flushes
    if ((state_q == WB || state_q == REFILL || state_q == RESP) && end_signal_i) begin
      end_pend_d = 1'b1;
    end

    busy_d       = (state_d == WB) || (state_d == REFILL) ||
                   (state_d == FLUSH_SCAN) || (state_d == FLUSH_WB);
    flush_done_d = flush_done_q || (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      scan_q       <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      end_pend_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      data_out_q   <= '0;
      ack_q        <= 1'b0;
      hit_q        <= 1'b0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      scan_q       <= scan_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      end_pend_q   <= end_pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      data_out_q   <= data_out_d;
      ack_q        <= ack_d;
      hit_q        <= hit_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Line and backing storage carry no reset; reset only blocks the write
  always_ff @(posedge clock) begin
    if (line_we && !reset) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign ack        = ack_q;
  assign hit        = hit_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule
